// File: rtl/img_pkg.sv
// Shared constants and types for the 3x3 window line-store datapath.
package img_pkg;

  localparam int unsigned LINE_W      = 512;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned N_LINES     = 4;
  localparam int unsigned PTR_W       = $clog2(LINE_W);
  localparam int unsigned SEL_W       = $clog2(N_LINES);
  localparam int unsigned CNT_W       = $clog2(N_LINES * LINE_W) + 1;
  localparam int unsigned READ_THRESH = 3 * LINE_W;
  localparam int unsigned FULL_CNT    = N_LINES * LINE_W;
  localparam int unsigned ROW_W       = 3 * PIX_W;
  localparam int unsigned WIN_W       = 9 * PIX_W;

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_e;

  // One window row, left-most pixel in the MSBs.
  typedef struct packed {
    logic [PIX_W-1:0] p0;
    logic [PIX_W-1:0] p1;
    logic [PIX_W-1:0] p2;
  } row_t;

  typedef struct packed {
    row_t top;
    row_t mid;
    row_t bot;
  } window_t;

endpackage

// File: rtl/line_store.sv
// One line of pixel storage: single write port, three adjacent-pixel read taps.
module line_store
  import img_pkg::*;
(
  input  logic               i_clk,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   wr_addr_i,
  input  logic [PIX_W-1:0]   wr_data_i,
  input  logic [PTR_W-1:0]   rd_addr_i,
  output logic [ROW_W-1:0]   taps_c_o
);

  logic [PIX_W-1:0] mem_q [LINE_W];

  always_ff @(posedge i_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Tap addresses wrap within the line so the last two windows fold back to pixels 0/1.
  always_comb begin
    taps_c_o = {mem_q[rd_addr_i],
                mem_q[PTR_W'(rd_addr_i + PTR_W'(1))],
                mem_q[PTR_W'(rd_addr_i + PTR_W'(2))]};
  end

endmodule

// File: rtl/image_window_ctrl.sv
// Writes a raster pixel stream round-robin into four line stores and reads three
// buffered lines out in lock-step as a 3x3 window, pulsing o_intr per consumed line.
module image_window_ctrl
  import img_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pixel_data,
  input  logic               i_pixel_data_valid,
  output logic [WIN_W-1:0]   o_pixel_data,
  output logic               o_pixel_data_valid,
  output logic               o_intr
);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_pix_cnt_q, wr_pix_cnt_d;
  logic [PTR_W-1:0]  rd_pix_cnt_q, rd_pix_cnt_d;
  logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]  total_cnt_q, total_cnt_d;
  logic              intr_q, intr_d;
  logic              wr_en_c, rd_en_c, rd_last_c;
  row_t              taps_c [N_LINES];
  window_t           win_c;

  // Pixels arriving while every store is full are dropped.
  assign wr_en_c   = i_pixel_data_valid && (total_cnt_q != CNT_W'(FULL_CNT));
  assign rd_last_c = (rd_pix_cnt_q == PTR_W'(LINE_W - 1));

  for (genvar g = 0; g < N_LINES; g++) begin : g_store
    line_store u_store (
      .i_clk     (i_clk),
      .wr_en_i   (wr_en_c && (wr_sel_q == SEL_W'(g))),
      .wr_addr_i (wr_pix_cnt_q),
      .wr_data_i (i_pixel_data),
      .rd_addr_i (rd_pix_cnt_q),
      .taps_c_o  (taps_c[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (total_cnt_q >= CNT_W'(READ_THRESH)) state_d = RD;
      RD:      if (rd_last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en_c = 1'b0;
    intr_d  = 1'b0;
    if (state_q == RD) begin
      rd_en_c = 1'b1;
      intr_d  = rd_last_c;
    end
  end

  always_comb begin
    wr_pix_cnt_d = wr_pix_cnt_q;
    wr_sel_d     = wr_sel_q;
    rd_pix_cnt_d = rd_pix_cnt_q;
    rd_sel_d     = rd_sel_q;
    total_cnt_d  = total_cnt_q;
    if (wr_en_c) begin
      wr_pix_cnt_d = PTR_W'(wr_pix_cnt_q + PTR_W'(1));
      if (wr_pix_cnt_q == PTR_W'(LINE_W - 1)) begin
        wr_sel_d = SEL_W'(wr_sel_q + SEL_W'(1));
      end
    end
    if (rd_en_c) begin
      rd_pix_cnt_d = PTR_W'(rd_pix_cnt_q + PTR_W'(1));
      if (rd_last_c) begin
        rd_sel_d = SEL_W'(rd_sel_q + SEL_W'(1));
      end
    end
    case ({wr_en_c, rd_en_c})
      2'b10:   total_cnt_d = CNT_W'(total_cnt_q + CNT_W'(1));
      2'b01:   total_cnt_d = CNT_W'(total_cnt_q - CNT_W'(1));
      default: total_cnt_d = total_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_pix_cnt_q <= '0;
      rd_pix_cnt_q <= '0;
      wr_sel_q     <= '0;
      rd_sel_q     <= '0;
      total_cnt_q  <= '0;
      intr_q       <= 1'b0;
    end else begin
      wr_pix_cnt_q <= wr_pix_cnt_d;
      rd_pix_cnt_q <= rd_pix_cnt_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      total_cnt_q  <= total_cnt_d;
      intr_q       <= intr_d;
    end
  end

  // Top row comes from rd_sel, the next two stores follow modulo four.
  always_comb begin
    win_c.top = taps_c[rd_sel_q];
    win_c.mid = taps_c[SEL_W'(rd_sel_q + SEL_W'(1))];
    win_c.bot = taps_c[SEL_W'(rd_sel_q + SEL_W'(2))];
  end

  assign o_pixel_data_valid = (state_q == RD);
  assign o_pixel_data       = o_pixel_data_valid ? win_c : '0;
  assign o_intr             = intr_q;

endmodule

// File: tb/tb_image_window_ctrl.sv
// Randomised self-checking bench for image_window_ctrl against a line-level reference model.
module tb_image_window_ctrl;

  localparam int LW   = 512;
  localparam int THR  = 3 * LW;
  localparam int FULL = 4 * LW;
  localparam int PW   = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [PW-1:0] i_pixel_data;
  logic          i_pixel_data_valid;
  logic [71:0]   o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_intr;

  image_window_ctrl dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted pixel history plus read progress in lines/positions.
  logic [PW-1:0] pix[$];
  int   acc, rd, lines_read, pos;
  logic m_exp_valid, m_exp_intr, wrap_ok;

  // Per-cycle observation and expectation published by step().
  logic        obs_valid, obs_intr, exp_valid, exp_intr, win_known;
  logic [71:0] obs_data, exp_win;
  int          obs_total, exp_total, cur_line, cur_pos;

  task automatic model_reset();
    pix.delete();
    acc = 0; rd = 0; lines_read = 0; pos = 0;
    m_exp_valid = 1'b0; m_exp_intr = 1'b0;
  endtask

  // Called at a falling edge: sample outputs, predict them, drive one input cycle.
  task automatic step(input logic v, input logic [PW-1:0] d);
    int   tot;
    logic take;
    obs_valid = o_pixel_data_valid;
    obs_intr  = o_intr;
    obs_data  = o_pixel_data;
    obs_total = int'(dut.total_cnt_q);
    tot       = acc - rd;
    exp_total = tot;
    exp_valid = m_exp_valid;
    exp_intr  = m_exp_intr;
    cur_line  = lines_read;
    cur_pos   = pos;
    exp_win   = '0;
    win_known = 1'b1;
    if (exp_valid) begin
      win_known = (pos <= LW - 3) || wrap_ok;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          exp_win[(8 - (r * 3 + c)) * PW +: PW] = pix[(lines_read + r) * LW + (pos + c) % LW];
    end
    take = v && (tot != FULL);
    i_pixel_data_valid = v;
    i_pixel_data       = d;
    @(posedge i_clk);
    m_exp_intr = 1'b0;
    if (exp_valid) begin
      rd++;
      pos++;
      if (pos == LW) begin
        pos = 0;
        lines_read++;
        m_exp_intr = 1'b1;
      end
    end
    if (take) begin
      pix.push_back(d);
      acc++;
    end
    m_exp_valid = exp_valid ? (pos != 0) : (tot >= THR);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_pixel_data_valid = 1'b0;
    i_pixel_data       = '0;
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    i_pixel_data_valid = 1'b0;
    i_pixel_data       = '0;
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_pixel_data_valid !== 1'b0 || o_intr !== 1'b0 || o_pixel_data !== 72'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid %b intr %b data %h, required 0 0 0", o_pixel_data_valid, o_intr, o_pixel_data);
    end
    n_checks++;
    if (dut.total_cnt_q !== 12'd0 || dut.wr_pix_cnt_q !== 9'd0 || dut.rd_pix_cnt_q !== 9'd0 ||
        dut.wr_sel_q !== 2'd0 || dut.rd_sel_q !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_counters: total %0d wr %0d rd %0d wsel %0d rsel %0d, required all 0",
               dut.total_cnt_q, dut.wr_pix_cnt_q, dut.rd_pix_cnt_q, dut.wr_sel_q, dut.rd_sel_q);
    end
    i_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_threshold();
    int nvalid = 0, nintr = 0, first_at = -1;
    logic [71:0] first_win = '0;
    wrap_ok = 1'b1;
    do_reset();
    for (int i = 0; i < THR - 1; i++) begin
      step(1'b1, 8'(i));
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win)) begin
        n_errors++;
        $display("FAIL fill cyc %0d: valid %b/%b intr %b/%b data %h/%h", i, obs_valid, exp_valid, obs_intr, exp_intr, obs_data, exp_win);
      end
      if (obs_valid) nvalid++;
      if (obs_intr) nintr++;
    end
    n_checks++;
    if (int'(dut.total_cnt_q) != THR - 1 || nvalid != 0 || nintr != 0) begin
      n_errors++;
      $display("FAIL fill_1535: total %0d valid_cycles %0d intr %0d, required 1535 0 0", dut.total_cnt_q, nvalid, nintr);
    end
    step(1'b1, 8'(THR - 1));
    for (int i = 0; i < LW + 4; i++) begin
      step(1'b0, 8'd0);
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win)) begin
        n_errors++;
        $display("FAIL first_line cyc %0d: valid %b/%b intr %b/%b data %h/%h", i, obs_valid, exp_valid, obs_intr, exp_intr, obs_data, exp_win);
      end
      if (obs_valid && first_at < 0) begin
        first_at  = i;
        first_win = obs_data;
      end
      if (obs_valid) nvalid++;
      if (obs_intr) nintr++;
    end
    n_checks++;
    if (first_at != 1 || first_win !== 72'h000102_000102_000102) begin
      n_errors++;
      $display("FAIL first_window: at %0d data %h, required 1 000102000102000102", first_at, first_win);
    end
    n_checks++;
    if (nvalid != LW || nintr != 1 || dut.rd_sel_q !== 2'd1) begin
      n_errors++;
      $display("FAIL first_pass: valid_cycles %0d intr %0d rd_sel %0d, required 512 1 1", nvalid, nintr, dut.rd_sel_q);
    end
    wrap_ok = 1'b0;
  endtask

  task automatic test_select_wrap();
    logic [71:0] w1 = '0, w4 = '0;
    int guard = 0;
    do_reset();
    for (int i = 0; i < 8 * LW; i++) begin
      step(1'b1, 8'(10 * (i / LW + 1)));
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win)) begin
        n_errors++;
        $display("FAIL wrap cyc %0d: valid %b/%b intr %b/%b data %h/%h", i, obs_valid, exp_valid, obs_intr, exp_intr, obs_data, exp_win);
      end
      if (obs_valid && cur_pos == 0 && cur_line == 1) w1 = obs_data;
      if (obs_valid && cur_pos == 0 && cur_line == 4) w4 = obs_data;
    end
    while (lines_read < 6 && guard < 4000) begin
      step(1'b0, 8'd0);
      guard++;
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win)) begin
        n_errors++;
        $display("FAIL wrap_drain cyc %0d: valid %b/%b intr %b/%b data %h/%h", guard, obs_valid, exp_valid, obs_intr, exp_intr, obs_data, exp_win);
      end
      if (obs_valid && cur_pos == 0 && cur_line == 4) w4 = obs_data;
    end
    n_checks++;
    if (w1 !== {{3{8'd20}}, {3{8'd30}}, {3{8'd40}}} || w4 !== {{3{8'd50}}, {3{8'd60}}, {3{8'd70}}}) begin
      n_errors++;
      $display("FAIL row_constants: pass1 %h pass4 %h, required 141414_1e1e1e_282828 and 323232_3c3c3c_464646", w1, w4);
    end
    n_checks++;
    if (guard >= 4000 || dut.rd_sel_q !== 2'd2 || dut.wr_sel_q !== 2'd0) begin
      n_errors++;
      $display("FAIL wrap_pointers: guard %0d rd_sel %0d wr_sel %0d, required <4000 2 0", guard, dut.rd_sel_q, dut.wr_sel_q);
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 0; i < THR + 3 * LW; i++) begin
      step(1'b1, 8'($urandom));
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win) || obs_total != exp_total) begin
        n_errors++;
        $display("FAIL concurrent cyc %0d: valid %b/%b intr %b/%b total %0d/%0d data %h/%h",
                 i, obs_valid, exp_valid, obs_intr, exp_intr, obs_total, exp_total, obs_data, exp_win);
      end
    end
  endtask

  task automatic test_random_stream();
    do_reset();
    for (int i = 0; i < 7000; i++) begin
      step(i < 5500 && $urandom_range(0, 3) != 0, 8'($urandom));
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win) || obs_total != exp_total) begin
        n_errors++;
        $display("FAIL random cyc %0d: valid %b/%b intr %b/%b total %0d/%0d data %h/%h",
                 i, obs_valid, exp_valid, obs_intr, exp_intr, obs_total, exp_total, obs_data, exp_win);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 2 * LW; i++) begin
      step(1'b1, (i < LW) ? 8'h33 : 8'h44);
      n_checks++;
      if (obs_valid !== exp_valid || obs_total != exp_total) begin
        n_errors++;
        $display("FAIL overflow_fill cyc %0d: valid %b/%b total %0d/%0d", i, obs_valid, exp_valid, obs_total, exp_total);
      end
    end
    do_reset();
    force dut.total_cnt_q = 12'd2048;
    i_pixel_data_valid = 1'b1;
    i_pixel_data       = 8'hFF;
    @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (dut.wr_pix_cnt_q !== 9'd0 || dut.wr_sel_q !== 2'd0 || dut.g_store[0].u_store.mem_q[0] !== 8'h33) begin
      n_errors++;
      $display("FAIL overflow_drop: wr_cnt %0d wr_sel %0d store0[0] %h, required 0 0 33",
               dut.wr_pix_cnt_q, dut.wr_sel_q, dut.g_store[0].u_store.mem_q[0]);
    end
    i_pixel_data_valid = 1'b0;
    release dut.total_cnt_q;
    do_reset();
  endtask

  task automatic test_reset_mid_line();
    logic [PW-1:0] npx [THR];
    logic [71:0]   first_win = '0;
    int guard = 0;
    do_reset();
    for (int i = 0; i < THR; i++) step(1'b1, 8'($urandom));
    while (!(m_exp_valid && pos == 200) && guard < 2000) begin
      step(1'b0, 8'd0);
      guard++;
    end
    n_checks++;
    if (guard >= 2000 || dut.rd_pix_cnt_q !== 9'd200 || o_pixel_data_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reach_200: guard %0d rd_cnt %0d valid %b, required <2000 200 1", guard, dut.rd_pix_cnt_q, o_pixel_data_valid);
    end
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (o_pixel_data_valid !== 1'b0 || o_intr !== 1'b0 || dut.total_cnt_q !== 12'd0 || dut.rd_pix_cnt_q !== 9'd0 ||
        dut.wr_pix_cnt_q !== 9'd0 || dut.rd_sel_q !== 2'd0 || dut.wr_sel_q !== 2'd0) begin
      n_errors++;
      $display("FAIL mid_reset: valid %b intr %b total %0d rd %0d wr %0d rsel %0d wsel %0d, required all 0",
               o_pixel_data_valid, o_intr, dut.total_cnt_q, dut.rd_pix_cnt_q, dut.wr_pix_cnt_q, dut.rd_sel_q, dut.wr_sel_q);
    end
    i_rst = 1'b1;
    model_reset();
    for (int i = 0; i < THR; i++) npx[i] = 8'($urandom);
    for (int i = 0; i < THR; i++) begin
      step(1'b1, npx[i]);
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr) begin
        n_errors++;
        $display("FAIL refill cyc %0d: valid %b/%b intr %b/%b", i, obs_valid, exp_valid, obs_intr, exp_intr);
      end
    end
    guard = 0;
    while (lines_read < 1 && guard < 1000) begin
      step(1'b0, 8'd0);
      guard++;
      n_checks++;
      if (obs_valid !== exp_valid || obs_intr !== exp_intr || (win_known && obs_data !== exp_win)) begin
        n_errors++;
        $display("FAIL restart cyc %0d: valid %b/%b intr %b/%b data %h/%h", guard, obs_valid, exp_valid, obs_intr, exp_intr, obs_data, exp_win);
      end
      if (obs_valid && cur_pos == 0) first_win = obs_data;
    end
    n_checks++;
    if (guard >= 1000 || first_win !== {npx[0], npx[1], npx[2], npx[LW], npx[LW+1], npx[LW+2], npx[2*LW], npx[2*LW+1], npx[2*LW+2]}) begin
      n_errors++;
      $display("FAIL restart_window: guard %0d data %h, required %h", guard, first_win,
               {npx[0], npx[1], npx[2], npx[LW], npx[LW+1], npx[LW+2], npx[2*LW], npx[2*LW+1], npx[2*LW+2]});
    end
  endtask

  initial begin
    i_rst = 1'b0;
    i_pixel_data_valid = 1'b0;
    i_pixel_data = '0;
    wrap_ok = 1'b0;
    model_reset();
    @(negedge i_clk);
    test_reset();
    test_fill_threshold();
    test_select_wrap();
    test_concurrent();
    test_random_stream();
    test_overflow();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/image_window_ctrl.md
Name: image_window_ctrl

Overview:
- Consumer side of the 512-pixel line-store datapath.
- Accepts a raster pixel stream and writes it round-robin into four internal line stores.
- Once three full lines are buffered, reads them out in lock-step as a 3x3 pixel window (72 bits) for the downstream convolution core.
- Pulses an interrupt each time one line has been consumed, so the DMA/upstream source can refill one line.

Parameters:
- LINE_W, 512, pixels per line (power of two; pointers are log2(LINE_W) bits).
- PIX_W, 8, bits per pixel.
- N_LINES, 4, number of internal line stores (fixed at 4; 3 read, 1 being written).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_pixel_data  in  PIX_W  incoming pixel.
- i_pixel_data_valid  in  1  pixel strobe; one pixel accepted per high cycle.
- o_pixel_data  out  9*PIX_W  3x3 window, row-major: {top row p0,p1,p2, mid row, bottom row}.
- o_pixel_data_valid  out  1  window valid.
- o_intr  out  1  one-cycle pulse when a line finishes being read.

Behaviour:
- Reset (async, i_rst low): all counters 0, wr_sel=0, rd_sel=0, state IDLE, o_pixel_data_valid=0, o_intr=0. Storage arrays are not reset.
- Write side:
  - wr_pix_cnt (0..LINE_W-1) increments on each accepted pixel.
  - Pixel goes to line store wr_sel at wr_pix_cnt.
  - On an accepted pixel with wr_pix_cnt==LINE_W-1, wr_pix_cnt wraps to 0 and wr_sel advances mod 4.
- Occupancy: total_cnt, 0..4*LINE_W, width log2(4*LINE_W)+1.
  - +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Overflow: i_pixel_data_valid while total_cnt==4*LINE_W is dropped. No store write, no counter change.
- FSM IDLE:
  - o_pixel_data_valid=0.
  - If total_cnt >= 3*LINE_W, go to RD next cycle; rd_active registers to 1.
- FSM RD:
  - rd_active=1; each cycle reads one window position and rd_pix_cnt increments.
  - When rd_pix_cnt==LINE_W-1: return to IDLE next cycle, rd_active=0, rd_pix_cnt wraps to 0, rd_sel advances mod 4, o_intr=1 for exactly that one following cycle.
  - The IDLE->RD re-check needs at least one IDLE cycle, so there is a minimum one-cycle gap between lines.
- Read taps:
  - Rows come from stores rd_sel, rd_sel+1, rd_sel+2 (all mod 4). Top row = rd_sel.
  - Each row gives pixels at rd_pix_cnt, +1, +2, with addresses mod LINE_W.
  - The last two windows of a line wrap to pixels 0/1 of the same row. This is accepted behaviour; the downstream core discards them.
- Output timing:
  - o_pixel_data is combinational from the taps, gated to 0 when o_pixel_data_valid=0.
  - o_pixel_data_valid = rd_active.
  - Window for position k is presented in the same cycle rd_pix_cnt==k.
- Hazard freedom: during RD, wr_sel is never one of the three read stores, provided the overflow rule holds. Writes and reads proceed concurrently.
- Reset mid-line: all counters and pointers return to 0. Partially written or read lines are abandoned, and o_intr is not emitted.

Decomposition:
- Shared package img_pkg:
  - Constants LINE_W, PIX_W, N_LINES, READ_THRESH (3*LINE_W).
  - FSM state typedef {IDLE, RD}.
- One natural sub-module, line_store, instantiated 4x:
  - Storage of LINE_W x PIX_W.
  - Write port: address and enable.
  - Read: 3-pixel tap output at base address.
- All sequencing, select logic and the FSM stay in image_window_ctrl.

Test Plan:
1. Reset, then stream 1535 pixels (value = index mod 256) -> o_pixel_data_valid stays 0, total_cnt==1535, o_intr never pulses.
2. Send the 1536th pixel -> o_pixel_data_valid rises 1 cycle later; first window is {0,1,2, 0,1,2, 0,1,2} with rows 0..2; 512 consecutive valid cycles; o_intr pulses once at the end; rd_sel==1.
3. With lines filled with row constants 10, 20, 30, 40 and continuous input -> second read pass rows are {20,20,20,30,30,30,40,40,40}, proving rd_sel/wr_sel wrap mod 4.
4. Simultaneous write and read every cycle during RD -> total_cnt constant at its value when RD started; no pixel lost or duplicated, verified by scoreboard.
5. Fill to 2048 with no reads, then assert valid with pixel 0xFF -> dropped; contents of store 0 unchanged; total_cnt==2048.
6. Assert i_rst at rd_pix_cnt==200 -> next edge: valid=0, o_intr=0, all counters 0; 1536 new pixels restart output from window 0.
